// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder
// Recovers a 4-bit hex digit from an active-low 7-segment pattern
// (bit0 = a ... bit6 = g). The pattern is synchronised, must hold steady
// before it is reported, and illegal patterns are flagged and counted.
// Results leave through a valid/ready handshake.
//
// Ports:
//   clock      in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   seg_in     in   [6:0] active-low segment pattern, asynchronous to clock
//   out_ready  in   consumer accepts result when high with out_valid
//   out_valid  out  result available
//   out_value  out  [3:0] decoded hex digit, 0 when out_err = 1
//   out_err    out  reported pattern is not a legal hex code
//   err_count  out  [ERR_W-1:0] saturating count of illegal reports
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [6:0]       seg_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       out_value,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [6:0] BLANK = 7'h7F;
  localparam int         CNT_W = 8;
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

  logic [6:0]       r_sync1;
  logic [6:0]       r_sync2;
  logic [6:0]       r_sync2_d;
  logic [6:0]       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic [3:0]       r_value;
  logic             r_err;
  logic [ERR_W-1:0] r_err_cnt;

  logic       w_legal;
  logic [3:0] w_digit;
  logic       w_blank;
  logic       w_stable;
  logic       w_slot_free;
  logic       w_report;

  always_comb begin
    w_legal = 1'b1;
    w_digit = 4'h0;
    case (r_sync2)
      7'h40: w_digit = 4'h0;
      7'h79: w_digit = 4'h1;
      7'h24: w_digit = 4'h2;
      7'h30: w_digit = 4'h3;
      7'h19: w_digit = 4'h4;
      7'h12: w_digit = 4'h5;
      7'h02: w_digit = 4'h6;
      7'h78: w_digit = 4'h7;
      7'h00: w_digit = 4'h8;
      7'h10: w_digit = 4'h9;
      7'h08: w_digit = 4'hA;
      7'h03: w_digit = 4'hB;
      7'h46: w_digit = 4'hC;
      7'h21: w_digit = 4'hD;
      7'h06: w_digit = 4'hE;
      7'h0E: w_digit = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end

  // The counter lags s2 by one cycle, so also require that s2 did not just
  // change; otherwise a pattern could be reported on the very cycle it
  // replaced the one that was actually held stable.
  assign w_blank     = (r_sync2 == BLANK);
  assign w_stable    = (r_cnt == STABLE_MAX) && (r_sync2 == r_sync2_d);
  assign w_slot_free = !r_valid || out_ready;
  assign w_report    = w_stable && (r_sync2 != r_last) && w_slot_free;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1   <= BLANK;
      r_sync2   <= BLANK;
      r_sync2_d <= BLANK;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= seg_in;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
      if (r_sync2 != r_sync2_d)
        r_cnt <= '0;
      else if (r_cnt != STABLE_MAX)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_last    <= BLANK;
      r_valid   <= 1'b0;
      r_value   <= 4'h0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (r_valid && out_ready)
        r_valid <= 1'b0;
      if (w_report) begin
        r_last <= r_sync2;
        // A blank only re-arms the decoder so the next digit is reported
        // even if it matches the one shown before the blank.
        if (!w_blank) begin
          r_valid <= 1'b1;
          r_value <= w_legal ? w_digit : 4'h0;
          r_err   <= !w_legal;
          if (!w_legal && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + 1'b1;
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign out_value = r_value;
  assign out_err   = r_err;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
module tb_seg7_pattern_decoder;

  localparam int S     = 4;
  localparam int ERR_W = 8;

  logic             clock = 1'b0;
  logic             resetn;
  logic [6:0]       seg_in;
  logic             out_ready;
  logic             out_valid;
  logic [3:0]       out_value;
  logic             out_err;
  logic [ERR_W-1:0] err_count;

  seg7_pattern_decoder #(.STABLE_CYCLES(S), .ERR_W(ERR_W)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .seg_in    (seg_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_value (out_value),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // legal code for each hex digit, index = digit
  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model: window of raw samples, newest at index 0
  logic [6:0] m_hist [$];
  logic [6:0] m_last;
  bit         m_valid;
  int         m_value;
  bit         m_err;
  int         m_errcnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (codes[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    repeat (S + 3) m_hist.push_back(7'h7F);
    m_last   = 7'h7F;
    m_valid  = 0;
    m_value  = 0;
    m_err    = 0;
    m_errcnt = 0;
  endtask

  // A pattern is reported once it has been sampled identically S+2 times,
  // ending two samples before the current edge (synchroniser delay).
  task automatic model_edge(input logic [6:0] seg, input bit rdy);
    bit         stable;
    bit         free;
    int         d;
    logic [6:0] p;
    p      = m_hist[1];
    stable = 1;
    for (int i = 2; i <= S + 2; i++)
      if (m_hist[i] != p) stable = 0;
    free = !m_valid || rdy;
    if (m_valid && rdy) m_valid = 0;
    if (stable && p != m_last && free) begin
      m_last = p;
      if (p != 7'h7F) begin
        d       = decode(p);
        m_valid = 1;
        m_err   = (d < 0);
        m_value = (d < 0) ? 0 : d;
        if (d < 0 && m_errcnt < 255) m_errcnt++;
      end
    end
    m_hist.push_front(seg);
    void'(m_hist.pop_back());
  endtask

  task automatic check_outputs();
    check_eq("valid", {31'd0, out_valid}, {31'd0, m_valid});
    check_eq("value", {28'd0, out_value}, m_value);
    check_eq("err", {31'd0, out_err}, {31'd0, m_err});
    check_eq("err_count", {24'd0, err_count}, m_errcnt);
  endtask

  // called just after a falling edge; drives inputs, advances one cycle
  task automatic step(input logic [6:0] seg, input bit rdy);
    seg_in    = seg;
    out_ready = rdy;
    @(posedge clock);
    if (!resetn) model_reset();
    else model_edge(seg, rdy);
    @(negedge clock);
    cyc++;
    check_outputs();
  endtask

  int n_valid;
  int first_v;
  int got_val;
  int sweep_q [$];
  int seen_err;
  logic [6:0] rpat;
  int hold;

  initial begin
    resetn    = 1'b0;
    seg_in    = 7'h7F;
    out_ready = 1'b1;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_outputs();
    resetn = 1'b1;

    // blank after reset: nothing reported
    n_valid = 0;
    for (int i = 0; i < 20; i++) begin
      step(7'h7F, 1);
      if (out_valid) n_valid++;
    end
    check_eq("blank_no_report", n_valid, 0);
    check_eq("blank_errcnt", {24'd0, err_count}, 0);

    // digit 2: latency and single report
    n_valid = 0; first_v = -1; got_val = -1;
    for (int i = 1; i <= 62; i++) begin
      step(7'h24, 1);
      if (out_valid) begin
        n_valid++;
        if (first_v < 0) begin first_v = i; got_val = out_value; end
      end
    end
    check_eq("lat_digit2", first_v, S + 4);
    check_eq("value_digit2", got_val, 2);
    check_eq("once_digit2", n_valid, 1);

    // sweep every legal code with blanks in between
    sweep_q.delete(); seen_err = 0;
    for (int d = 0; d < 16; d++) begin
      for (int i = 0; i < 10; i++) begin
        step(codes[d], 1);
        if (out_valid) begin sweep_q.push_back(out_value); if (out_err) seen_err++; end
      end
      for (int i = 0; i < 10; i++) begin
        step(7'h7F, 1);
        if (out_valid) begin sweep_q.push_back(out_value); if (out_err) seen_err++; end
      end
    end
    check_eq("sweep_count", sweep_q.size(), 16);
    for (int d = 0; d < 16 && d < sweep_q.size(); d++)
      check_eq("sweep_value", sweep_q[d], d);
    check_eq("sweep_err", seen_err, 0);

    // short glitch rejected
    n_valid = 0;
    step(7'h7F, 1);
    repeat (3) begin step(7'h79, 1); if (out_valid) n_valid++; end
    repeat (10) begin step(7'h7F, 1); if (out_valid) n_valid++; end
    check_eq("glitch_no_report", n_valid, 0);

    // illegal pattern
    first_v = -1;
    for (int i = 1; i <= 10; i++) begin
      step(7'h55, 1);
      if (out_valid && first_v < 0) begin
        first_v = i;
        check_eq("illegal_err", {31'd0, out_err}, 1);
        check_eq("illegal_value", {28'd0, out_value}, 0);
        check_eq("illegal_count", {24'd0, err_count}, 1);
      end
    end
    check_eq("illegal_lat", first_v, S + 4);

    // saturate the error counter
    for (int n = 0; n < 260; n++) begin
      repeat (8) step(7'h7F, 1);
      repeat (8) step(7'h55, 1);
    end
    check_eq("errcnt_sat", {24'd0, err_count}, 255);

    // backpressure
    repeat (10) step(7'h7F, 1);
    repeat (10) step(7'h30, 0);
    check_eq("bp_hold_valid", {31'd0, out_valid}, 1);
    check_eq("bp_hold_value3", {28'd0, out_value}, 3);
    repeat (10) step(7'h12, 0);
    check_eq("bp_still3", {28'd0, out_value}, 3);
    step(7'h12, 1);
    check_eq("b2b_valid", {31'd0, out_valid}, 1);
    check_eq("b2b_value5", {28'd0, out_value}, 5);
    step(7'h12, 1);
    n_valid = 0;
    repeat (10) begin step(7'h12, 1); if (out_valid) n_valid++; end
    check_eq("bp_no_repeat", n_valid, 0);

    // reset while a result is pending
    repeat (10) step(7'h7F, 1);
    first_v = -1;
    for (int i = 1; i <= 20 && first_v < 0; i++) begin
      step(7'h00, 0);
      if (out_valid) first_v = i;
    end
    check_eq("pre_rst_valid", {31'd0, out_valid}, 1);
    check_eq("pre_rst_value8", {28'd0, out_value}, 8);
    resetn = 1'b0;
    #1;
    check_eq("rst_async_valid", {31'd0, out_valid}, 0);
    check_eq("rst_async_value", {28'd0, out_value}, 0);
    check_eq("rst_async_errcnt", {24'd0, err_count}, 0);
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    first_v = -1;
    for (int i = 1; i <= 20 && first_v < 0; i++) begin
      step(7'h00, 1);
      if (out_valid) first_v = i;
    end
    check_eq("post_rst_lat", first_v, S + 4);
    check_eq("post_rst_value8", {28'd0, out_value}, 8);

    // randomized patterns, hold times and backpressure
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: rpat = 7'h7F;
        1: rpat = 7'($urandom_range(0, 127));
        default: rpat = codes[$urandom_range(0, 15)];
      endcase
      hold = $urandom_range(1, 12);
      repeat (hold) step(rpat, ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
